// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl -- soft-start duty scheduler for the left/right wheel PWMs.
//
// Commands arrive over a valid/ready handshake. Each one is parked in a
// per-channel pending slot. The slot becomes the channel target on the next
// PWM period boundary. Each channel then slews its duty toward the target by
// STEP once every RAMP_PERIODS PWM periods. Because of this, a PWM period
// never sees a duty change in the middle of the period.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous reset, active low
//   period_end  1-cycle pulse at PWM counter wrap (shared by both channels)
//   cmd_valid   command present
//   cmd_ready   pending slot of channel cmd_ch is free
//   cmd_ch      0 = left, 1 = right
//   cmd_duty    requested target duty (clamped to MAX_DUTY on accept)
//   duty_l/r    registered duty for the left/right PWM
//   at_tgt_l/r  registered: channel idle at its target, nothing pending
//   estop       emergency stop (present only when PWM_RAMP_ESTOP_EN is defined)
//
// Build option: define PWM_RAMP_ESTOP_EN to add the synchronous estop input.
module pwm_ramp_ctrl #(
  parameter int WIDTH        = 10,
  parameter int STEP         = 8,
  parameter int RAMP_PERIODS = 4,
  parameter int MAX_DUTY     = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             period_end,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_ch,
  input  logic [WIDTH-1:0] cmd_duty,
  output logic [WIDTH-1:0] duty_l,
  output logic [WIDTH-1:0] duty_r,
  output logic             at_tgt_l,
  output logic             at_tgt_r
`ifdef PWM_RAMP_ESTOP_EN
  ,
  input  logic             estop
`endif
);

  typedef enum logic [1:0] {HOLD, UP, DOWN} state_t;

  localparam int               CW     = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [CW-1:0]    LAST   = CW'(RAMP_PERIODS - 1);
  localparam logic [WIDTH-1:0] MAX_D  = WIDTH'(MAX_DUTY);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [WIDTH:0]   STEP_D = (WIDTH + 1)'(STEP);

  logic             stop;
  logic [CW-1:0]    cnt_reg;
  logic             tick;
  logic             accept;
  logic [WIDTH-1:0] cmd_clamped;
  logic [WIDTH-1:0] duty_arr     [2];
  logic             pend_vld_arr [2];
  logic             at_tgt_arr   [2];

`ifdef PWM_RAMP_ESTOP_EN
  assign stop = estop;
`else
  assign stop = 1'b0;
`endif

  assign cmd_ready   = ~pend_vld_arr[cmd_ch] & ~stop;
  assign accept      = cmd_valid & cmd_ready;
  assign cmd_clamped = (cmd_duty > MAX_D) ? MAX_D : cmd_duty;
  assign tick        = period_end && (cnt_reg == LAST);

  // Count period_end pulses; the last one of each group is the ramp tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (stop) begin
      cnt_reg <= '0;
    end else if (period_end) begin
      cnt_reg <= tick ? '0 : cnt_reg + CW'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      state_t           state_reg, state_next;
      logic [WIDTH-1:0] duty_reg, duty_next;
      logic [WIDTH-1:0] tgt_reg;
      logic [WIDTH-1:0] pend_reg;
      logic             pend_vld_reg;
      logic             at_tgt_reg;
      logic [WIDTH:0]   up_gap, dn_gap;

      // One extra bit, so each gap is exact when its direction applies.
      assign up_gap = {1'b0, tgt_reg} - {1'b0, duty_reg};
      assign dn_gap = {1'b0, duty_reg} - {1'b0, tgt_reg};

      // The FSM compares against the registered target. A pending copy in
      // the same cycle is therefore seen one cycle later.
      always_comb begin
        state_next = state_reg;
        duty_next  = duty_reg;
        case (state_reg)
          HOLD: begin
            if (duty_reg < tgt_reg)      state_next = UP;
            else if (duty_reg > tgt_reg) state_next = DOWN;
          end
          UP: begin
            if (duty_reg > tgt_reg)       state_next = DOWN;
            else if (duty_reg == tgt_reg) state_next = HOLD;
            else if (tick) begin
              if (up_gap <= STEP_D) begin
                duty_next  = tgt_reg;
                state_next = HOLD;
              end else begin
                duty_next = duty_reg + STEP_W;
              end
            end
          end
          DOWN: begin
            if (duty_reg < tgt_reg)       state_next = UP;
            else if (duty_reg == tgt_reg) state_next = HOLD;
            else if (tick) begin
              if (dn_gap <= STEP_D) begin
                duty_next  = tgt_reg;
                state_next = HOLD;
              end else begin
                duty_next = duty_reg - STEP_W;
              end
            end
          end
          default: state_next = HOLD;
        endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_reg    <= HOLD;
          duty_reg     <= '0;
          tgt_reg      <= '0;
          pend_reg     <= '0;
          pend_vld_reg <= 1'b0;
          at_tgt_reg   <= 1'b1;
        end else if (stop) begin
          state_reg    <= HOLD;
          duty_reg     <= '0;
          tgt_reg      <= '0;
          pend_vld_reg <= 1'b0;
          at_tgt_reg   <= 1'b1;
        end else begin
          state_reg  <= state_next;
          duty_reg   <= duty_next;
          at_tgt_reg <= (state_reg == HOLD) && (duty_reg == tgt_reg) && !pend_vld_reg;
          // The slot is accepted only while empty and copied only while full,
          // so these two branches never compete for the slot.
          if (period_end && pend_vld_reg) begin
            tgt_reg      <= pend_reg;
            pend_vld_reg <= 1'b0;
          end else if (accept && (cmd_ch == 1'(gi))) begin
            pend_reg     <= cmd_clamped;
            pend_vld_reg <= 1'b1;
          end
        end
      end

      assign duty_arr[gi]     = duty_reg;
      assign pend_vld_arr[gi] = pend_vld_reg;
      assign at_tgt_arr[gi]   = at_tgt_reg;
    end
  endgenerate

  assign duty_l   = duty_arr[0];
  assign duty_r   = duty_arr[1];
  assign at_tgt_l = at_tgt_arr[0];
  assign at_tgt_r = at_tgt_arr[1];

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Testbench for pwm_ramp_ctrl.
// The reference model tracks duty, target and pending slots as integers.
// A ramp tick moves the duty by min(STEP, distance) toward the target.
// Every cycle, the bench compares cmd_ready, both duties and both at_tgt
// flags against this model. Directed steps are followed by a randomized phase.
module tb_pwm_ramp_ctrl;
  localparam int W    = 10;
  localparam int STEP = 8;
  localparam int RP   = 4;
  localparam int MAXD = 1000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         period_end = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ch = 1'b0;
  logic [W-1:0] cmd_duty = '0;
  logic         cmd_ready;
  logic [W-1:0] duty_l, duty_r;
  logic         at_tgt_l, at_tgt_r;
`ifdef PWM_RAMP_ESTOP_EN
  logic         estop = 1'b0;
`endif

  always #5 clk = ~clk;

  pwm_ramp_ctrl #(.WIDTH(W), .STEP(STEP), .RAMP_PERIODS(RP), .MAX_DUTY(MAXD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .period_end (period_end),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_ch     (cmd_ch),
    .cmd_duty   (cmd_duty),
    .duty_l     (duty_l),
    .duty_r     (duty_r),
    .at_tgt_l   (at_tgt_l),
    .at_tgt_r   (at_tgt_r)
`ifdef PWM_RAMP_ESTOP_EN
    ,
    .estop      (estop)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_duty [2];
  int m_tgt  [2];
  int m_pend [2];
  bit m_pvld [2];
  bit m_at   [2];
  bit m_tchg [2];   // target value changed at the last edge
  int m_cnt;

  int gap = 16;     // clocks between period_end pulses (always >= 2)
  int phase = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int c = 0; c < 2; c++) begin
      m_duty[c] = 0; m_tgt[c] = 0; m_pend[c] = 0;
      m_pvld[c] = 0; m_at[c] = 1; m_tchg[c] = 0;
    end
    m_cnt = 0;
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic m_clock(bit pe, bit v, bit ch, int d, bit es);
    bit tick, acc;
    bit term [2];
    if (es) begin
      for (int c = 0; c < 2; c++) begin
        m_duty[c] = 0; m_tgt[c] = 0; m_pvld[c] = 0; m_at[c] = 1; m_tchg[c] = 0;
      end
      m_cnt = 0;
      return;
    end
    tick = pe && (m_cnt == RP - 1);
    acc  = v && !m_pvld[ch];
    // A channel settles one cycle after its target has moved onto the current duty.
    for (int c = 0; c < 2; c++)
      term[c] = (m_duty[c] == m_tgt[c]) && !m_pvld[c] && !m_tchg[c];
    if (pe) m_cnt = tick ? 0 : m_cnt + 1;
    for (int c = 0; c < 2; c++) begin
      if (tick) begin
        if (m_duty[c] < m_tgt[c])      m_duty[c] = (m_duty[c] + STEP > m_tgt[c]) ? m_tgt[c] : m_duty[c] + STEP;
        else if (m_duty[c] > m_tgt[c]) m_duty[c] = (m_duty[c] - STEP < m_tgt[c]) ? m_tgt[c] : m_duty[c] - STEP;
      end
      m_tchg[c] = 0;
      if (pe && m_pvld[c]) begin
        m_tchg[c] = (m_pend[c] != m_tgt[c]);
        m_tgt[c]  = m_pend[c];
        m_pvld[c] = 0;
      end else if (acc && (ch == c[0])) begin
        m_pend[c] = (d > MAXD) ? MAXD : d;
        m_pvld[c] = 1;
      end
      m_at[c] = term[c];
    end
  endtask

  // Run one clock with the given inputs and check the DUT against the model.
  task automatic cyc(bit v, bit ch, int d, bit es = 0);
    bit pe;
    pe = (phase == gap - 1);
    period_end = pe;
    cmd_valid  = v;
    cmd_ch     = ch;
    cmd_duty   = W'(d);
`ifdef PWM_RAMP_ESTOP_EN
    estop = es;
`endif
    #1;
    chk("cmd_ready", 32'(cmd_ready), (es || m_pvld[ch]) ? 32'd0 : 32'd1);
    @(posedge clk);
    if (rst_n) m_clock(pe, v, ch, d, es);
    phase = pe ? 0 : phase + 1;
    #1;
    chk("duty_l", 32'(duty_l), 32'(m_duty[0]));
    chk("duty_r", 32'(duty_r), 32'(m_duty[1]));
    chk("at_tgt_l", 32'(at_tgt_l), 32'(m_at[0]));
    chk("at_tgt_r", 32'(at_tgt_r), 32'(m_at[1]));
  endtask

  task automatic send(bit ch, int d);
    int n;
    bit ok;
    n = 0;
    forever begin
      ok = !m_pvld[ch];
      cyc(1, ch, d);
      if (ok) break;
      n++;
      if (n > 400) begin
        checks++; failures++;
        $error("FAIL send_timeout ch=%0d observed=stalled expected=accepted", ch);
        break;
      end
    end
    cmd_valid = 1'b0;
    $display("send ch=%0d duty=%0d accepted_after=%0d", ch, d, n);
  endtask

  task automatic wait_duty(int c, int val, int bound);
    int n;
    n = 0;
    while (m_duty[c] != val) begin
      if (n >= bound) begin
        checks++; failures++;
        $error("FAIL wait_duty ch=%0d observed=%0d expected=%0d", c, m_duty[c], val);
        return;
      end
      cyc(0, 0, 0);
      n++;
    end
  endtask

  task automatic settle(int bound);
    int n;
    n = 0;
    while (!(m_duty[0] == m_tgt[0] && m_duty[1] == m_tgt[1] && !m_pvld[0] && !m_pvld[1]
             && m_at[0] && m_at[1])) begin
      if (n >= bound) begin
        checks++; failures++;
        $error("FAIL settle_timeout observed=%0d/%0d expected=%0d/%0d",
               m_duty[0], m_duty[1], m_tgt[0], m_tgt[1]);
        return;
      end
      cyc(0, 0, 0);
      n++;
    end
    $display("settled duty_l=%0d duty_r=%0d after %0d clk", duty_l, duty_r, n);
  endtask

  task automatic set_gap(int g);
    while (phase != 0) cyc(0, 0, 0);
    gap = g;
  endtask

  initial begin
    m_reset();
    // 1: reset held while period_end keeps pulsing
    #1 rst_n = 1'b0;
    #1;
    repeat (20) cyc(0, 0, 0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    rst_n = 1'b1;

    // 2: ramp up 0 -> 20 on the left channel
    send(0, 20);
    wait_duty(0, 8, 600);
    chk("t2_at_mid", 32'(at_tgt_l), 32'd0);
    wait_duty(0, 16, 600);
    settle(1000);
    chk("t2_final_l", 32'(duty_l), 32'd20);
    chk("t2_final_r", 32'(duty_r), 32'd0);
    chk("t2_at_l", 32'(at_tgt_l), 32'd1);

    // 3: ramp down with reversal
    send(0, 100);
    settle(2000);
    send(0, 40);
    wait_duty(0, 92, 600);
    chk("t3_first_down", 32'(duty_l), 32'd92);
    send(0, 120);
    settle(2000);
    chk("t3_final", 32'(duty_l), 32'd120);

    // 4: backpressure on ch1, ch0 accepted inside the stalled window
    while (phase != 2) cyc(0, 0, 0);
    cyc(1, 1, 24);
    cmd_valid = 1'b1; cmd_ch = 1'b1; cmd_duty = W'(40);
    #1 chk("t4_stall", 32'(cmd_ready), 32'd0);
    cyc(1, 1, 40);
    cyc(1, 0, 50);
    chk("t4_ch1_still_stalled", 32'(m_pvld[1]), 32'd1);
    send(1, 40);
    settle(2000);
    chk("t4_final_r", 32'(duty_r), 32'd40);
    chk("t4_final_l", 32'(duty_l), 32'd50);

    // 5: clamp and edges, with fast period_end to keep the run short
    set_gap(2);
    send(1, 1023);
    settle(3000);
    chk("t5_clamp", 32'(duty_r), 32'd1000);
    send(0, 5);
    settle(1000);
    send(0, 0);
    settle(1000);
    chk("t5_zero", 32'(duty_l), 32'd0);

    // 6: asynchronous reset mid-ramp
    send(0, 200);
    wait_duty(0, 48, 1000);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_l", 32'(duty_l), 32'd0);
    chk("t6_async_r", 32'(duty_r), 32'd0);
    chk("t6_async_ready", 32'(cmd_ready), 32'd1);
    m_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(0, 16);
    settle(1000);
    chk("t6_restart", 32'(duty_l), 32'd16);

`ifdef PWM_RAMP_ESTOP_EN
    send(1, 100);
    repeat (30) cyc(0, 0, 0);
    repeat (3) cyc(0, 0, 0, 1'b1);
    chk("estop_l", 32'(duty_l), 32'd0);
    chk("estop_r", 32'(duty_r), 32'd0);
    send(1, 24);
    settle(1000);
    chk("estop_restart", 32'(duty_r), 32'd24);
`endif

    // Randomized commands with varying period_end spacing
    for (int i = 0; i < 600; i++) begin
      if (phase == 0) gap = $urandom_range(2, 6);
      cyc(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), $urandom_range(0, 1023));
    end
    cmd_valid = 1'b0;
    set_gap(2);
    settle(4000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
